// File: rtl/mem_port_arbiter_pkg.sv
// Shared cache-side definitions: line/address types and the memory-port arbiter state encoding.
// Request/response records stay unpacked elsewhere, so the arbiter flattens them at its ports.
package mem_port_arbiter_pkg;

    localparam int LINE_W              = 128;
    localparam int ADDR_W              = 32;
    localparam int ARB_TIMEOUT_DEFAULT = 256;

    typedef logic [LINE_W-1:0] cache_data_type;
    typedef logic [ADDR_W-1:0] cache_addr_type;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win last time is chosen.
module mem_port_arbiter_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_valid
);

    always_comb begin
        any_valid = |valid;
        unique case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single cache-to-memory port between the I-cache (0) and D-cache (1) controllers,
// holding the winning request on the port until memory answers or the transaction times out.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 9
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    input  logic         req0_rw,
    input  logic [31:0]  req0_addr,
    input  logic [127:0] req0_wdata,
    output logic         req0_ready,
    output logic [127:0] req0_rdata,
    output logic         req0_err,

    input  logic         req1_valid,
    input  logic         req1_rw,
    input  logic [31:0]  req1_addr,
    input  logic [127:0] req1_wdata,
    output logic         req1_ready,
    output logic [127:0] req1_rdata,
    output logic         req1_err,

    output logic         mem_req_valid,
    output logic         mem_req_rw,
    output logic [31:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    input  logic         mem_rsp_ready,
    input  logic [127:0] mem_rsp_data,

    output logic         grant_id,
    output logic         busy
);

    if (TIMEOUT_CYC < 0 || (2 ** CNT_W) <= TIMEOUT_CYC) begin : g_bad_cnt_w
        $error("CNT_W is too narrow to count to TIMEOUT_CYC");
    end

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    arb_state_t     state_q,      state_d;
    logic           last_grant_q, last_grant_d;
    logic           grant_id_q,   grant_id_d;
    logic           mem_valid_q,  mem_valid_d;
    logic           rw_q,         rw_d;
    cache_addr_type addr_q,       addr_d;
    cache_data_type wdata_q,      wdata_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic           ready0_q,     ready0_d;
    logic           ready1_q,     ready1_d;
    logic           err0_q,       err0_d;
    logic           err1_q,       err1_d;
    cache_data_type rdata0_q,     rdata0_d;
    cache_data_type rdata1_q,     rdata1_d;

    logic           arb_grant;
    logic           arb_any;
    logic           timeout_hit;
    logic           finish;
    logic           finish_err;
    cache_data_type finish_line;

    mem_port_arbiter_rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .any_valid  (arb_any)
    );

    // A response arriving on the timeout cycle takes priority, so err only when memory stayed silent.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
    assign finish      = mem_rsp_ready || timeout_hit;
    assign finish_err  = !mem_rsp_ready;
    assign finish_line = (mem_rsp_ready && !rw_q) ? mem_rsp_data : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        mem_valid_d  = mem_valid_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_id_d   = arb_grant;
                    last_grant_d = arb_grant;
                    rw_d         = arb_grant ? req1_rw    : req0_rw;
                    addr_d       = arb_grant ? req1_addr  : req0_addr;
                    wdata_d      = arb_grant ? req1_wdata : req0_wdata;
                    cnt_d        = '0;
                    mem_valid_d  = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (finish) begin
                    mem_valid_d = 1'b0;
                    state_d     = DONE;
                    if (grant_id_q) begin
                        ready1_d = 1'b1;
                        err1_d   = finish_err;
                        rdata1_d = finish_line;
                    end else begin
                        ready0_d = 1'b1;
                        err0_d   = finish_err;
                        rdata0_d = finish_line;
                    end
                end
            end
            // The pulse cycle never arbitrates, giving the owner one edge to drop its valid.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            mem_valid_q  <= mem_valid_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign req0_ready    = ready0_q;
    assign req0_err      = err0_q;
    assign req0_rdata    = rdata0_q;
    assign req1_ready    = ready1_q;
    assign req1_err      = err1_q;
    assign req1_rdata    = rdata1_q;
    assign mem_req_valid = mem_valid_q;
    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_data  = wdata_q;
    assign grant_id      = grant_id_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a transaction-level model of the port.
module tb_mem_port_arbiter;

    localparam int TMO = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [1:0]   rv    = '0;
    logic [1:0]   rrw   = '0;
    logic [31:0]  raddr [2];
    logic [127:0] rwd   [2];
    logic         mem_rsp_ready = 1'b0;
    logic [127:0] mem_rsp_data  = '0;

    logic         req0_ready, req1_ready, req0_err, req1_err;
    logic [127:0] req0_rdata, req1_rdata, mem_req_data;
    logic [31:0]  mem_req_addr;
    logic         mem_req_valid, mem_req_rw, grant_id, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.TIMEOUT_CYC(TMO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(rv[0]), .req0_rw(rrw[0]), .req0_addr(raddr[0]), .req0_wdata(rwd[0]),
        .req0_ready(req0_ready), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(rv[1]), .req1_rw(rrw[1]), .req1_addr(raddr[1]), .req1_wdata(rwd[1]),
        .req1_ready(req1_ready), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_w32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_w128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy_of(input logic id);
        return id ? req1_ready : req0_ready;
    endfunction

    function automatic logic err_of(input logic id);
        return id ? req1_err : req0_err;
    endfunction

    function automatic logic [127:0] rdata_of(input logic id);
        return id ? req1_rdata : req0_rdata;
    endfunction

    // Transaction-level model: a transaction is either absent, holding the memory port, or
    // in its single completion cycle; rounds alternate the winner under contention.
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_owner = 1'b0;
    logic         m_last  = 1'b1;
    logic         m_err   = 1'b0;
    int           m_age   = 0;
    logic         m_rw    = 1'b0;
    logic [31:0]  m_addr  = '0;
    logic [127:0] m_wdata = '0;
    logic [127:0] m_rdata [2] = '{default: '0};

    function automatic logic pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return !last;
        return v[1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_owner <= 1'b0;
            m_last  <= 1'b1;
            m_err   <= 1'b0;
            m_age   <= 0;
            m_rw    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '{default: '0};
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (mem_rsp_ready) begin
                m_rdata[m_owner] <= m_rw ? 128'h0 : mem_rsp_data;
                m_err  <= 1'b0;
                m_done <= 1'b1;
            end else if (TMO != 0 && m_age + 1 == TMO) begin
                m_rdata[m_owner] <= '0;
                m_err  <= 1'b1;
                m_done <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (rv != 2'b00) begin
            m_owner <= pick(rv, m_last);
            m_last  <= pick(rv, m_last);
            m_rw    <= rrw[pick(rv, m_last)];
            m_addr  <= raddr[pick(rv, m_last)];
            m_wdata <= rwd[pick(rv, m_last)];
            m_busy  <= 1'b1;
            m_age   <= 0;
        end
    end

    always @(negedge clk) begin
        check_bit("mem_req_valid", mem_req_valid, m_busy && !m_done);
        check_bit("mem_req_rw", mem_req_rw, m_rw);
        check_w32("mem_req_addr", mem_req_addr, m_addr);
        check_w128("mem_req_data", mem_req_data, m_wdata);
        check_bit("req0_ready", req0_ready, m_done && !m_owner);
        check_bit("req1_ready", req1_ready, m_done && m_owner);
        check_bit("req0_err", req0_err, m_done && !m_owner && m_err);
        check_bit("req1_err", req1_err, m_done && m_owner && m_err);
        check_w128("req0_rdata", req0_rdata, m_rdata[0]);
        check_w128("req1_rdata", req1_rdata, m_rdata[1]);
        check_bit("grant_id", grant_id, m_owner);
        check_bit("busy", busy, m_busy);
    end

    // Wait for the port to carry a request, answer it after lat cycles and check the pulse.
    task automatic serve(input int lat, input logic [127:0] rsp, input logic gid, input logic rw,
                         input logic [31:0] addr, input logic [127:0] wd, input bit keep,
                         output int t_start);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_bit("serve_req_seen", mem_req_valid, 1'b1);
        t_start = cyc;
        check_bit("serve_grant", grant_id, gid);
        check_bit("serve_rw", mem_req_rw, rw);
        check_w32("serve_addr", mem_req_addr, addr);
        check_w128("serve_wdata", mem_req_data, wd);
        repeat (lat) @(negedge clk);
        mem_rsp_ready = 1'b1;
        mem_rsp_data  = rsp;
        @(negedge clk);
        mem_rsp_ready = 1'b0;
        check_bit("serve_ready", rdy_of(gid), 1'b1);
        check_bit("serve_other_ready", rdy_of(!gid), 1'b0);
        check_bit("serve_err", err_of(gid), 1'b0);
        check_w128("serve_rdata", rdata_of(gid), rw ? 128'h0 : rsp);
        if (!keep) rv[gid] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ts, tprev, high, r, lat_left;
        logic mv_prev;
        logic [127:0] d;
        raddr[0] = '0; raddr[1] = '0; rwd[0] = '0; rwd[1] = '0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset_mem_req_valid", mem_req_valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_grant_id", grant_id, 1'b0);
        check_bit("reset_req0_ready", req0_ready, 1'b0);
        rst_n = 1'b1;

        // Simultaneous read/write: requester 0 first, then the write from requester 1.
        @(negedge clk);
        rv = 2'b11; rrw = 2'b10;
        raddr[0] = 32'h0000_0100; rwd[0] = '0;
        raddr[1] = 32'h0000_0200; rwd[1] = {16{8'hA5}};
        serve(1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1'b0, 32'h100, '0, 1'b0, ts);
        serve(1, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 1'b1, 1'b1, 32'h200,
              {16{8'hA5}}, 1'b0, ts);

        // Fairness: both held valid, latency 1, alternating owners every 4 cycles.
        @(negedge clk);
        rv = 2'b11; rrw = 2'b00;
        raddr[0] = 32'h0000_0300; rwd[0] = {4{32'h0F0F_0F0F}};
        raddr[1] = 32'h0000_0400; rwd[1] = {4{32'hF0F0_F0F0}};
        tprev = 0;
        for (int k = 0; k < 4; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            serve(1, d, k[0], 1'b0, k[0] ? 32'h400 : 32'h300,
                  k[0] ? {4{32'hF0F0_F0F0}} : {4{32'h0F0F_0F0F}}, 1'b1, ts);
            if (k > 0) check_w32("fair_period", ts - tprev, 32'd4);
            tprev = ts;
        end
        rv = 2'b00;

        // Single read with 3-cycle memory latency.
        @(negedge clk);
        @(negedge clk);
        rv = 2'b01; rrw = 2'b00; raddr[0] = 32'h0000_4000; rwd[0] = '0;
        t0 = cyc;
        serve(3, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1'b0, 1'b0, 32'h4000, '0, 1'b0, ts);
        check_w32("single_req_latency", ts - t0, 32'd1);
        @(negedge clk);
        check_bit("single_pulse_one_cycle", req0_ready, 1'b0);
        check_w128("single_rdata_hold", req0_rdata, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);

        // Timeout: memory silent, port held exactly TMO cycles, then a late response is ignored.
        rv = 2'b01; raddr[0] = 32'h0000_5000;
        high = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_req_valid) high++;
            if (req0_ready) break;
        end
        check_bit("timeout_ready", req0_ready, 1'b1);
        check_bit("timeout_err", req0_err, 1'b1);
        check_w128("timeout_rdata", req0_rdata, 128'h0);
        check_w32("timeout_valid_cycles", high, 32'd8);
        rv = 2'b00;
        repeat (5) @(negedge clk);
        mem_rsp_ready = 1'b1;
        mem_rsp_data  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        mem_rsp_ready = 1'b0;
        check_bit("late_rsp_no_pulse", req0_ready, 1'b0);
        check_bit("late_rsp_idle", busy, 1'b0);

        // Collision: response presented on the timeout cycle wins.
        rv = 2'b10; rrw = 2'b00; raddr[1] = 32'h0000_6000; rwd[1] = '0;
        serve(7, 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D, 1'b1, 1'b0, 32'h6000, '0, 1'b0, ts);

        // Reset mid-BUSY: request port drops at once, contention afterwards goes to requester 0.
        @(negedge clk);
        rv = 2'b01; rrw = 2'b10;
        raddr[0] = 32'h0000_7000; rwd[0] = '0;
        raddr[1] = 32'h0000_8000; rwd[1] = {8{16'h5A5A}};
        @(negedge clk);
        rv = 2'b11;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_bit("async_reset_mem_valid", mem_req_valid, 1'b0);
        check_bit("async_reset_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        serve(0, 128'h7777_0000_7777_0000_7777_0000_7777_0000, 1'b0, 1'b0, 32'h7000, '0, 1'b0, ts);
        serve(0, 128'h0, 1'b1, 1'b1, 32'h8000, {8{16'h5A5A}}, 1'b0, ts);

        // Randomized traffic with varied latency, collisions, timeouts and stray responses.
        lat_left = -1;
        mv_prev  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rv[i] && rdy_of(i[0])) begin
                    rv[i] = 1'b0;
                end else if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i]    = 1'b1;
                    rrw[i]   = 1'($urandom_range(0, 1));
                    raddr[i] = $urandom & 32'hFFFF_FFF0;
                    rwd[i]   = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            mem_rsp_ready = 1'b0;
            if (mem_req_valid) begin
                if (!mv_prev) begin
                    r = int'($urandom_range(0, 19));
                    lat_left = (r < 14) ? (r % 4) : ((r < 17) ? TMO - 1 : TMO + 4);
                end
                if (lat_left == 0) begin
                    mem_rsp_ready = 1'b1;
                    mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
                end
                lat_left--;
            end else if ($urandom_range(0, 7) == 0) begin
                mem_rsp_ready = 1'b1;
                mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            mv_prev = mem_req_valid;
        end
        rv = 2'b00;
        mem_rsp_ready = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
